kband_onchip_mem_dp: RTL and testbench
======================================

# kband_onchip_mem_dp

Parametrised true-dual-port on-chip memory for the KBand accelerator, the successor to the fixed 128-bit × 4096 single-port Avalon buffer. It exposes two independent Avalon-MM slaves: s1 for the HPS/LW bridge and s2 for the alignment datapath. Both ports support byte-enabled writes, a configurable pipelined read latency with `readdatavalid`, and deterministic collision arbitration. The block replaces single-port buffers wherever host and core must share tables concurrently.

## Interface
- `DATA_W`, default 128: word width, a multiple of 8.
- `DEPTH`, default 4096: number of words, a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `RD_LAT`, default 1: read latency, 1 or 2 (2 adds an output register).
- `INIT_FILE`, default "kband_onchip_mem_dp.hex": power-up contents.
- `clk`, in, 1: single clock for both ports.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clken`, in, 1: global clock enable; 0 freezes the block.
- `sX_address`, in, ADDR_W: word address (X = 1, 2).
- `sX_chipselect`, in, 1: port select.
- `sX_read`, in, 1: read request.
- `sX_write`, in, 1: write request.
- `sX_byteenable`, in, DATA_W/8: byte lanes to write.
- `sX_writedata`, in, DATA_W: write data.
- `sX_readdata`, out, DATA_W: read data.
- `sX_readdatavalid`, out, 1: `sX_readdata` valid this cycle.
- `sX_waitrequest`, out, 1: request not accepted; master holds it.

## Operation
- Accept rule: a request is accepted when `chipselect & (read|write) & ~waitrequest & clken`.
- Read and write asserted together on one port: treated as a write only; no `readdatavalid` follows.
- Writes: only lanes with `byteenable` = 1 are updated. All-zero `byteenable` is accepted and changes nothing.
- Collision, both ports writing the same address in the same cycle:
  - s1 is accepted.
  - `s2_waitrequest` = 1 for that cycle.
  - s2 is accepted on the following cycle.
- All other simultaneous accesses, including two writes to different addresses, are accepted together with no wait.
- Read and write to the same address from different ports in the same cycle: the read returns the old data (read-before-write).
- `clken` = 0:
  - Both `waitrequest` outputs = 1.
  - Read pipelines hold their state.
  - `readdatavalid` outputs are forced to 0.
  - Held data emerges once `clken` returns to 1.
- Reset:
  - All `readdata` outputs = 0, all `readdatavalid` outputs = 0.
  - `waitrequest` outputs = 0, or 1 while clearing (see Configuration).
  - Reads in flight are discarded.
  - Memory array contents are not altered by reset.

## Timing
- A read accepted at edge N gives `readdatavalid` = 1 with data in cycle N+RD_LAT (counting only cycles where `clken` = 1).
- A write accepted at edge N is visible to a read on either port accepted at N+1 or later.
- Throughput: one access per port per cycle. Back-to-back reads produce back-to-back valid beats.
- `readdatavalid` is high for exactly one cycle per accepted read. `readdata` is undefined when `readdatavalid` = 0.
- `waitrequest` is combinational from the same-cycle requests (collision) and from `clken`/clear state only.

## Configuration
- `KBAND_MEM_CLEAR_EN` defined: a clear sequencer is compiled in.
  - States: CLEAR → READY.
  - Reset enters CLEAR with a counter at 0.
  - Each `clken` cycle writes zeros to address = counter through the port-1 side, then increments the counter.
  - After writing DEPTH−1 the sequencer moves to READY.
  - Both `waitrequest` outputs = 1 throughout CLEAR.
  - Reset asserted mid-clear restarts the counter at 0.
- `KBAND_MEM_CLEAR_EN` undefined: the block is READY from reset, contents come from `INIT_FILE`, and there is no clear counter.

## Structure
- Package `kband_mem_pkg` holds:
  - the clear state enum (CLEAR, READY);
  - the `RD_LAT` legality check;
  - a byte-enable width function.
- Sub-module `kband_mem_rd_pipe`: per-port valid/data pipeline of depth `RD_LAT` with `clken` hold. It is instantiated twice.

## Test plan
- s1 writes 0xA5…A5 to address 7 with all byte enables, then s2 reads address 7 → `s2_readdatavalid` at N+RD_LAT with 0xA5…A5.
- s1 writes with `byteenable` = 0x0001 and data 0xFF over prior 0 → only byte 0 = 0xFF, all other bytes 0.
- Both ports write address 3 in the same cycle (s1 = 1, s2 = 2) → `s2_waitrequest` = 1 for one cycle; a final read of address 3 returns 2.
- 4 back-to-back s2 reads with RD_LAT = 2, with `clken` dropped for 3 cycles mid-burst → 4 valid beats, correct order, no valid beat while `clken` = 0.
- Reset with a read in flight → no `readdatavalid` after reset; `readdata` = 0.
- With `KBAND_MEM_CLEAR_EN`, DEPTH = 16: `waitrequest` = 1 for 16 cycles after reset, then reads of all addresses return 0.

Source files
------------

// File: rtl/kband_mem_pkg.sv
// Shared types and elaboration helpers for the KBand dual-port on-chip memory.
package kband_mem_pkg;

  typedef enum logic {CLEAR, READY} clr_state_e;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/kband_mem_rd_pipe.sv
// Read-return pipeline of depth RD_LAT; every stage freezes while clken is low.
module kband_mem_rd_pipe #(
  parameter int DATA_W = 128,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else if (clken) begin
      vld_q[0] <= in_vld;
      if (in_vld) dat_q[0] <= in_dat;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // A beat parked at the last stage is withheld, not lost, while clken is low.
  assign out_vld = vld_q[RD_LAT-1] & clken;
  assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/kband_onchip_mem_dp.sv
// True dual-port Avalon-MM memory; s1 wins same-address write collisions.
// Define KBAND_MEM_CLEAR_EN to zero the array after reset instead of relying on INIT_FILE.
module kband_onchip_mem_dp
  import kband_mem_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = "kband_onchip_mem_dp.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int BE_W = be_width(DATA_W);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("kband_onchip_mem_dp: RD_LAT must be 1 or 2");
  end

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;

`ifdef KBAND_MEM_CLEAR_EN
  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (clken) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = READY;
    end
  end

  assign clearing = (state == CLEAR);
  assign clr_addr = cnt;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  logic s1_req, s2_req, collide;
  logic s1_we, s1_re, s2_we, s2_re;

  assign s1_req  = s1_chipselect & (s1_read | s1_write);
  assign s2_req  = s2_chipselect & (s2_read | s2_write);
  assign collide = s1_chipselect & s1_write & s2_chipselect & s2_write &
                   (s1_address == s2_address);

  assign s1_waitrequest = ~clken | clearing;
  assign s2_waitrequest = ~clken | clearing | collide;

  // Read+write on one port is a pure write: no read beat is launched.
  assign s1_we = s1_req & ~s1_waitrequest & s1_write;
  assign s1_re = s1_req & ~s1_waitrequest & s1_read & ~s1_write;
  assign s2_we = s2_req & ~s2_waitrequest & s2_write;
  assign s2_re = s2_req & ~s2_waitrequest & s2_read & ~s2_write;

  // The clear sequencer borrows the port-1 write path; s1 is stalled meanwhile.
  logic              w1_en;
  logic [ADDR_W-1:0] w1_addr;
  logic [BE_W-1:0]   w1_be;
  logic [DATA_W-1:0] w1_dat;

  assign w1_en   = s1_we | (clearing & clken);
  assign w1_addr = clearing ? clr_addr : s1_address;
  assign w1_be   = clearing ? '1 : s1_byteenable;
  assign w1_dat  = clearing ? '0 : s1_writedata;

  // Same-address dual writes never reach here together, so lane order is irrelevant.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (w1_en && w1_be[b]) mem[w1_addr][b*8 +: 8] <= w1_dat[b*8 +: 8];
      if (s2_we && s2_byteenable[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
    end
  end

  // Capturing the pre-edge array value gives read-before-write across ports.
  kband_mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_s1 (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .in_vld  (s1_re),
    .in_dat  (mem[s1_address]),
    .out_vld (s1_readdatavalid),
    .out_dat (s1_readdata)
  );

  kband_mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_s2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .in_vld  (s2_re),
    .in_dat  (mem[s2_address]),
    .out_vld (s2_readdatavalid),
    .out_dat (s2_readdata)
  );

endmodule

// File: tb/tb_kband_onchip_mem_dp.sv
// Directed bench for kband_onchip_mem_dp at DEPTH=16, RD_LAT=2 (also builds with KBAND_MEM_CLEAR_EN).
module tb_kband_onchip_mem_dp;

  localparam int DW = 128;
  localparam int AW = 4;
  localparam int BW = 16;
`ifdef KBAND_MEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  localparam logic [DW-1:0] A5   = {16{8'hA5}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] Z    = '0;
  localparam logic          L    = 1'b0;
  localparam logic          H    = 1'b1;

  typedef struct packed {
    logic          cs, rd, wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] dat;
  } port_t;

  typedef struct packed {
    port_t         p1, p2;
    logic          ew1, ew2;
    logic          ev1;
    logic [DW-1:0] ed1;
    logic          ev2;
    logic [DW-1:0] ed2;
  } vec_t;

  localparam port_t IDLE = '0;

  logic          clk, reset_n, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  int n_cmp = 0;
  int n_err = 0;

  kband_onchip_mem_dp #(.DATA_W(DW), .DEPTH(16), .RD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic port_t p_wr(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                 input logic [DW-1:0] d);
    return '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: be, dat: d};
  endfunction

  function automatic port_t p_rw(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                 input logic [DW-1:0] d);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b1, addr: a, be: be, dat: d};
  endfunction

  function automatic port_t p_rd(input logic [AW-1:0] a);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: '0, dat: '0};
  endfunction

  task automatic drive(input port_t p1, input port_t p2);
    s1_chipselect = p1.cs; s1_read = p1.rd; s1_write = p1.wr;
    s1_address = p1.addr; s1_byteenable = p1.be; s1_writedata = p1.dat;
    s2_chipselect = p2.cs; s2_read = p2.rd; s2_write = p2.wr;
    s2_address = p2.addr; s2_byteenable = p2.be; s2_writedata = p2.dat;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  vec_t          tbl [20];
  logic [DW-1:0] beats [$];
  int            idx, viol, waits, nbeat;

  initial begin
    tbl[0]  = '{p_wr(4'd7, 16'hFFFF, A5),   IDLE,                         L, L, L, Z, L, Z};
    tbl[1]  = '{IDLE,                       p_rd(4'd7),                   L, L, L, Z, L, Z};
    tbl[2]  = '{p_wr(4'd5, 16'hFFFF, Z),    IDLE,                         L, L, L, Z, L, Z};
    tbl[3]  = '{p_wr(4'd5, 16'h0001, ONES), IDLE,                         L, L, L, Z, H, A5};
    tbl[4]  = '{p_rd(4'd5),                 IDLE,                         L, L, L, Z, L, Z};
    tbl[5]  = '{IDLE,                       IDLE,                         L, L, L, Z, L, Z};
    tbl[6]  = '{p_wr(4'd3, 16'hFFFF, 128'd1), p_wr(4'd3, 16'hFFFF, 128'd2), L, H, H, 128'hFF, L, Z};
    tbl[7]  = '{IDLE,                       p_wr(4'd3, 16'hFFFF, 128'd2), L, L, L, Z, L, Z};
    tbl[8]  = '{p_rd(4'd3),                 p_rd(4'd7),                   L, L, L, Z, L, Z};
    tbl[9]  = '{p_rd(4'd7),                 p_wr(4'd7, 16'hFFFF, 128'h1234), L, L, L, Z, L, Z};
    tbl[10] = '{p_rd(4'd7),                 IDLE,                         L, L, H, 128'd2, H, A5};
    tbl[11] = '{IDLE,                       IDLE,                         L, L, H, A5, L, Z};
    tbl[12] = '{p_rw(4'd9, 16'hFFFF, 128'h55), p_wr(4'd10, 16'hFFFF, 128'h66), L, L, H, 128'h1234, L, Z};
    tbl[13] = '{p_rd(4'd9),                 p_rd(4'd10),                  L, L, L, Z, L, Z};
    tbl[14] = '{IDLE,                       IDLE,                         L, L, L, Z, L, Z};
    tbl[15] = '{IDLE,                       IDLE,                         L, L, H, 128'h55, H, 128'h66};
    tbl[16] = '{p_wr(4'd9, 16'h0000, ONES), IDLE,                         L, L, L, Z, L, Z};
    tbl[17] = '{p_rd(4'd9),                 IDLE,                         L, L, L, Z, L, Z};
    tbl[18] = '{IDLE,                       IDLE,                         L, L, L, Z, L, Z};
    tbl[19] = '{IDLE,                       IDLE,                         L, L, H, 128'h55, L, Z};

    reset_n = 1'b0;
    clken   = 1'b1;
    drive(IDLE, IDLE);
    @(negedge clk);
    chk("reset s1_readdata", s1_readdata, Z);
    chk("reset s2_readdata", s2_readdata, Z);
    chk("reset s1_readdatavalid", 128'(s1_readdatavalid), 128'(0));
    chk("reset s2_readdatavalid", 128'(s2_readdatavalid), 128'(0));
    chk("reset s1_waitrequest", 128'(s1_waitrequest), 128'(CLR));
    chk("reset s2_waitrequest", 128'(s2_waitrequest), 128'(CLR));

    @(posedge clk); #1 reset_n = 1'b1;
    waits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!s1_waitrequest && !s2_waitrequest) break;
      waits++;
    end
    chk("wait cycles after reset", 128'(waits), CLR ? 128'(16) : 128'(0));

`ifdef KBAND_MEM_CLEAR_EN
    nbeat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      drive((k < 16) ? p_rd(4'(k)) : IDLE, IDLE);
      @(negedge clk);
      if (s1_readdatavalid) begin
        chk($sformatf("cleared word %0d", nbeat), s1_readdata, Z);
        nbeat++;
      end
    end
    chk("cleared beat count", 128'(nbeat), 128'(16));
`endif

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].p1, tbl[i].p2);
      @(negedge clk);
      chk($sformatf("row%0d s1_waitrequest", i), 128'(s1_waitrequest), 128'(tbl[i].ew1));
      chk($sformatf("row%0d s2_waitrequest", i), 128'(s2_waitrequest), 128'(tbl[i].ew2));
      chk($sformatf("row%0d s1_readdatavalid", i), 128'(s1_readdatavalid), 128'(tbl[i].ev1));
      chk($sformatf("row%0d s2_readdatavalid", i), 128'(s2_readdatavalid), 128'(tbl[i].ev2));
      if (tbl[i].ev1) chk($sformatf("row%0d s1_readdata", i), s1_readdata, tbl[i].ed1);
      if (tbl[i].ev2) chk($sformatf("row%0d s2_readdata", i), s2_readdata, tbl[i].ed2);
    end

    // Burst of four s2 reads with clken low for three cycles in the middle.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(IDLE, p_wr(4'(k), 16'hFFFF, 128'(8'h10 + k)));
    end
    idx  = 0;
    viol = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      clken = !(k >= 2 && k <= 4);
      drive(IDLE, (idx < 4) ? p_rd(4'(idx)) : IDLE);
      @(negedge clk);
      if (s2_readdatavalid) begin
        if (!clken) viol++;
        beats.push_back(s2_readdata);
      end
      if (s2_chipselect && s2_read && !s2_waitrequest) idx++;
    end
    clken = 1'b1;
    chk("burst valid while clken low", 128'(viol), 128'(0));
    chk("burst beat count", 128'(beats.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst beat %0d", i), (i < beats.size()) ? beats[i] : 'x, 128'(8'h10 + i));

    // Reset lands while a read sits in the pipeline.
    @(posedge clk); #1 drive(p_rd(4'd7), IDLE);
    @(posedge clk); #1 drive(IDLE, IDLE);
    #2 reset_n = 1'b0;
    #1;
    chk("mid-reset s1_readdatavalid", 128'(s1_readdatavalid), 128'(0));
    chk("mid-reset s1_readdata", s1_readdata, Z);
    @(posedge clk); #1 reset_n = 1'b1;
    nbeat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s1_readdatavalid) nbeat++;
    end
    chk("valid beats after reset", 128'(nbeat), 128'(0));
    chk("readdata after reset", s1_readdata, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
